// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store with 1-cycle responses.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after MAX_STREAK contended data grants.
module mem_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_f_req,
  input  logic [31:0] i_f_addr,
  output logic        o_f_gnt,
  output logic        o_f_rsp_valid,
  output logic [31:0] o_f_rsp_data,
  output logic        o_f_rsp_err,
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wr_data,
  input  logic [1:0]  i_d_wr_mask,
  input  logic [2:0]  i_d_rd_mask,
  output logic        o_d_gnt,
  output logic        o_d_rsp_valid,
  output logic [31:0] o_d_rsp_data,
  output logic        o_d_rsp_err_misaligned,
  output logic        o_d_rsp_err_mask,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_err_address_misaligned,
  input  logic        i_mem_err_invalid_read_mask
);
  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_e;
  owner_e owner_q, owner_d;
  logic err_q, err_d, no_rd_q, no_rd_d;
  logic force_f, f_bad, d_bad;
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] streak_q, streak_d;
  assign force_f = i_f_req && i_d_req && (streak_q == 4'(MAX_STREAK));
  always_comb streak_d = (!i_f_req || o_f_gnt) ? 4'd0 : (o_d_gnt ? streak_q + 4'd1 : streak_q);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) streak_q <= 4'd0;
    else streak_q <= streak_d;
`else
  assign force_f = 1'b0 & (MAX_STREAK != 0);
`endif
  assign o_f_gnt = i_reset_n && i_f_req && (!i_d_req || force_f);
  assign o_d_gnt = i_reset_n && i_d_req && !force_f;
  assign f_bad = i_f_addr[1:0] != 2'd0;
  assign d_bad = ((i_d_wr_mask == 2'd3 || i_d_rd_mask == 3'd0) && i_d_addr[1:0] != 2'd0) ||
                 ((i_d_wr_mask == 2'd2 || i_d_rd_mask == 3'd1 || i_d_rd_mask == 3'd3) && i_d_addr[0]);
  always_comb begin
    o_mem_address = 32'd0;
    o_mem_wr_data = 32'd0;
    o_mem_wr_mask = 2'd0;
    o_mem_rd_mask = 3'd5;
    owner_d = OWN_NONE;
    err_d = 1'b0;
    no_rd_d = 1'b0;
    if (o_f_gnt) begin
      owner_d = OWN_F;
      err_d = f_bad;
      if (!f_bad) begin
        o_mem_address = i_f_addr;
        o_mem_rd_mask = 3'd0;
      end
    end else if (o_d_gnt) begin
      owner_d = OWN_D;
      err_d = d_bad;
      no_rd_d = i_d_rd_mask == 3'd5;
      if (!d_bad) begin
        o_mem_address = i_d_addr;
        o_mem_wr_data = i_d_wr_data;
        o_mem_wr_mask = i_d_wr_mask;
        o_mem_rd_mask = i_d_rd_mask;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      owner_q <= OWN_NONE;
      err_q <= 1'b0;
      no_rd_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q <= err_d;
      no_rd_q <= no_rd_d;
    end
  // A locally rejected access never reached memory, so its read data is meaningless.
  assign o_f_rsp_valid = owner_q == OWN_F;
  assign o_f_rsp_data = (o_f_rsp_valid && !err_q) ? i_mem_rd_data : 32'd0;
  assign o_f_rsp_err = o_f_rsp_valid && (err_q || i_mem_err_address_misaligned || i_mem_err_invalid_read_mask);
  assign o_d_rsp_valid = owner_q == OWN_D;
  assign o_d_rsp_data = (o_d_rsp_valid && !err_q && !no_rd_q) ? i_mem_rd_data : 32'd0;
  assign o_d_rsp_err_misaligned = o_d_rsp_valid && (err_q || i_mem_err_address_misaligned);
  assign o_d_rsp_err_mask = o_d_rsp_valid && i_mem_err_invalid_read_mask;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic f_req, d_req, f_gnt, d_gnt, f_v, f_e, d_v, d_em, d_ek, mem_mis, mem_inv;
  logic [31:0] f_addr, d_addr, d_wd, f_d, d_d, m_a, m_wd, mem_rd;
  logic [1:0] d_wm, m_wm;
  logic [2:0] d_rm, m_rm;
  logic [31:0] mem [0:63];
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int due; logic fv; logic [31:0] fd; logic fe; logic dv; logic [31:0] dd; logic dm; logic dk;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
    .o_f_rsp_valid(f_v), .o_f_rsp_data(f_d), .o_f_rsp_err(f_e),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_wr_data(d_wd), .i_d_wr_mask(d_wm), .i_d_rd_mask(d_rm),
    .o_d_gnt(d_gnt), .o_d_rsp_valid(d_v), .o_d_rsp_data(d_d),
    .o_d_rsp_err_misaligned(d_em), .o_d_rsp_err_mask(d_ek),
    .o_mem_address(m_a), .o_mem_wr_data(m_wd), .o_mem_wr_mask(m_wm), .o_mem_rd_mask(m_rm),
    .i_mem_rd_data(mem_rd), .i_mem_err_address_misaligned(mem_mis), .i_mem_err_invalid_read_mask(mem_inv)
  );

  // Memory: registered read of the pre-write word, byte/half/word writes, reloaded while in reset.
  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0] b;
    logic [1:0] o;
    w = mem[m_a[7:2]];
    o = m_a[1:0];
    h = o[1] ? w[31:16] : w[15:0];
    b = w[8*o +: 8];
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 0) ? 32'h0800_0200 : (32'h1000_0000 | i);
      mem_rd <= 32'd0;
      mem_inv <= 1'b0;
      mem_mis <= 1'b0;
    end else begin
      case (m_rm)
        3'd0: mem_rd <= w;
        3'd1: mem_rd <= {16'd0, h};
        3'd2: mem_rd <= {24'd0, b};
        3'd3: mem_rd <= {{16{h[15]}}, h};
        3'd4: mem_rd <= {{24{b[7]}}, b};
        default: mem_rd <= 32'd0;
      endcase
      mem_inv <= m_rm > 3'd5;
      mem_mis <= 1'b0;
      if (m_wm == 2'd1) mem[m_a[7:2]][8*o +: 8] <= m_wd[7:0];
      if (m_wm == 2'd2) mem[m_a[7:2]][16*o[1] +: 16] <= m_wd[15:0];
      if (m_wm == 2'd3) mem[m_a[7:2]] <= m_wd;
    end
  end

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({f_v, f_d, f_e, d_v, d_d, d_em, d_ek} !== {e.fv, e.fd, e.fe, e.dv, e.dd, e.dm, e.dk}) begin
        errors++;
        $display("FAIL rsp cyc %0d got f(v%b d%h e%b) d(v%b d%h m%b k%b) want f(v%b d%h e%b) d(v%b d%h m%b k%b)",
                 cyc, f_v, f_d, f_e, d_v, d_d, d_em, d_ek, e.fv, e.fd, e.fe, e.dv, e.dd, e.dm, e.dk);
      end
    end
  end

  function automatic exp_t en();
    exp_t e = '{cyc + 1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
    return e;
  endfunction
  function automatic exp_t ef(input logic [31:0] data, input logic err);
    exp_t e = '{cyc + 1, 1'b1, data, err, 1'b0, 32'd0, 1'b0, 1'b0};
    return e;
  endfunction
  function automatic exp_t ed(input logic [31:0] data, input logic mis, input logic msk);
    exp_t e = '{cyc + 1, 1'b0, 32'd0, 1'b0, 1'b1, data, mis, msk};
    return e;
  endfunction

  task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da,
                       input logic [31:0] wd, input logic [1:0] wm, input logic [2:0] rm);
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_wd = wd; d_wm = wm; d_rm = rm;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    drive(0, 0, 0, 0, 0, 0, 5);
    sb.push_back(en());
    tick();
  endtask

  task automatic test_reset;
    drive(1, 0, 1, 4, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({f_gnt, d_gnt, f_v, d_v, f_d, d_d} !== 68'd0) begin
      errors++; $display("FAIL reset_out got gnt %b%b v %b%b", f_gnt, d_gnt, f_v, d_v);
    end
    checks++;
    if ({m_a, m_wd, m_wm, m_rm} !== {32'd0, 32'd0, 2'd0, 3'd5}) begin
      errors++; $display("FAIL reset_mem got a %h wm %0d rm %0d want 0 0 5", m_a, m_wm, m_rm);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({f_gnt, d_gnt} !== 2'b01) begin
      errors++; $display("FAIL reset_first_gnt got %b%b want 01", f_gnt, d_gnt);
    end
    sb.push_back(ed(32'h1000_0001, 0, 0));
    tick();
    idle();
  endtask

  task automatic test_fetch_word;
    drive(1, 0, 0, 0, 0, 0, 5);
    checks++;
    if ({f_gnt, d_gnt} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt got %b%b want 10", f_gnt, d_gnt);
    end
    sb.push_back(ef(32'h0800_0200, 0));
    tick();
    idle();
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 32'(4 * i), 0, 0, 0, 0, 5);
      checks++;
      if ({f_gnt, m_a, m_rm} !== {1'b1, 32'(4 * i), 3'd0}) begin
        errors++; $display("FAIL b2b_gnt%0d got g%b a %h rm %0d", i, f_gnt, m_a, m_rm);
      end
      sb.push_back(ef(32'h1000_0000 | 32'(i), 0));
      tick();
    end
    idle();
  endtask

  task automatic test_store_load;
    logic [31:0] da [5] = '{6, 6, 6, 8, 8};
    logic [31:0] wd [5] = '{32'h80, 0, 0, 32'hDEAD_BEEF, 0};
    logic [1:0]  wm [5] = '{1, 0, 0, 3, 0};
    logic [2:0]  rm [5] = '{5, 4, 2, 0, 0};
    logic [31:0] ex [5] = '{0, 32'hFFFF_FF80, 32'h0000_0080, 32'h1000_0002, 32'hDEAD_BEEF};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, da[i], wd[i], wm[i], rm[i]);
      checks++;
      if ({d_gnt, m_wm, m_rm} !== {1'b1, wm[i], rm[i]}) begin
        errors++; $display("FAIL sl_gnt%0d got g%b wm %0d rm %0d", i, d_gnt, m_wm, m_rm);
      end
      sb.push_back(ed(ex[i], 0, 0));
      tick();
    end
    idle();
  endtask

  task automatic test_misaligned;
    drive(0, 0, 1, 2, 32'hFFFF_FFFF, 3, 5);
    checks++;
    if ({d_gnt, m_wm, m_rm, m_a} !== {1'b1, 2'd0, 3'd5, 32'd0}) begin
      errors++; $display("FAIL mis_store got g%b wm %0d rm %0d a %h", d_gnt, m_wm, m_rm, m_a);
    end
    sb.push_back(ed(0, 1, 0));
    tick();
    drive(1, 1, 0, 0, 0, 0, 5);
    checks++;
    if ({f_gnt, m_rm} !== {1'b1, 3'd5}) begin
      errors++; $display("FAIL mis_fetch got g%b rm %0d want 1 5", f_gnt, m_rm);
    end
    sb.push_back(ef(0, 1));
    tick();
    drive(0, 0, 1, 5, 0, 0, 1);
    sb.push_back(ed(0, 1, 0));
    tick();
    drive(0, 0, 1, 6, 0, 0, 3);
    sb.push_back(ed(32'h0000_1080, 0, 0));
    tick();
    drive(0, 0, 1, 3, 0, 0, 4);
    sb.push_back(ed(32'h0000_0008, 0, 0));
    tick();
    idle();
    checks++;
    if (mem[0] !== 32'h0800_0200) begin
      errors++; $display("FAIL mis_mem got %h want 08000200", mem[0]);
    end
  endtask

  task automatic test_starvation;
    for (int i = 0; i < 10; i++) begin
      logic want_f;
      want_f = GUARD && (i % 5 == 4);
      drive(1, 0, 1, 0, 0, 0, 5);
      checks++;
      if ({f_gnt, d_gnt} !== {want_f, !want_f}) begin
        errors++; $display("FAIL starve%0d got %b%b want %b%b", i, f_gnt, d_gnt, want_f, !want_f);
      end
      sb.push_back(want_f ? ef(32'h0800_0200, 0) : ed(0, 0, 0));
      tick();
    end
    idle();
  endtask

  task automatic test_invalid_mask;
    drive(0, 0, 1, 0, 0, 0, 6);
    checks++;
    if ({d_gnt, m_rm} !== {1'b1, 3'd6}) begin
      errors++; $display("FAIL inv_gnt got g%b rm %0d want 1 6", d_gnt, m_rm);
    end
    sb.push_back(ed(0, 0, 1));
    tick();
    idle();
  endtask

  task automatic test_reset_mid;
    drive(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_gnt got %b want 1", d_gnt);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({f_v, d_v, d_d, d_gnt, m_rm} !== {35'd0, 3'd5}) begin
      errors++; $display("FAIL rmid_drop got v %b%b d %h g %b rm %0d", f_v, d_v, d_d, d_gnt, m_rm);
    end
    drive(0, 0, 0, 0, 0, 0, 5);
    rst_n = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 5);
    test_reset();
    test_fetch_word();
    test_back_to_back();
    test_store_load();
    test_misaligned();
    test_starvation();
    test_invalid_mask();
    test_reset_mid();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port `Memory` between the instruction-fetch stage and the load/store stage. Each cycle it grants at most one request, drives the memory's address, data and mask inputs, and routes the registered read data and error flags back to the requester that owns the in-flight access. It rejects misaligned accesses locally before they reach memory, and it keeps fetch from starving under back-to-back data traffic.

## Interface
Parameters:
- `MAX_STREAK`, default 4: maximum consecutive contended data grants before fetch is forced through. Legal range is 1..15.

Ports:
- `i_clk`  in  1  clock
- `i_reset_n`  in  1  asynchronous, active-low reset
- `i_f_req`  in  1  fetch request; held until granted
- `i_f_addr`  in  32  fetch byte address; always a word read
- `o_f_gnt`  out  1  fetch request accepted this cycle (combinational)
- `o_f_rsp_valid`  out  1  fetch response valid
- `o_f_rsp_data`  out  32  fetch read data
- `o_f_rsp_err`  out  1  fetch misaligned (addr[1:0] != 0)
- `i_d_req`  in  1  data request; held until granted
- `i_d_addr`  in  32  data byte address
- `i_d_wr_data`  in  32  store data
- `i_d_wr_mask`  in  2  0=none, 1=byte, 2=half, 3=word
- `i_d_rd_mask`  in  3  0=W, 1=HZ, 2=BZ, 3=HE, 4=BE, 5=no read
- `o_d_gnt`  out  1  data request accepted this cycle (combinational)
- `o_d_rsp_valid`  out  1  data response or store acknowledge valid
- `o_d_rsp_data`  out  32  load data; 0 when rd_mask=5 or the request was rejected
- `o_d_rsp_err_misaligned`  out  1  misaligned access
- `o_d_rsp_err_mask`  out  1  invalid read mask (forwarded from memory)
- `o_mem_address`, `o_mem_wr_data`  out  32  to Memory
- `o_mem_wr_mask`  out  2  to Memory
- `o_mem_rd_mask`  out  3  to Memory
- `i_mem_rd_data`  in  32  from Memory
- `i_mem_err_address_misaligned`, `i_mem_err_invalid_read_mask`  in  1  from Memory

## Operation
- **Arbitration.** Each cycle with a request pending:
  - If only one port requests, that port is granted.
  - If both request, data wins, except in the starvation-guard case (see Configuration).
  - A request is consumed on the cycle its `gnt` is asserted. A requester may present a new request the following cycle.
- **Idle memory drive.** When nothing is granted, or the granted request is rejected locally:
  - `o_mem_wr_mask`=0 and `o_mem_rd_mask`=5.
  - `o_mem_address` and `o_mem_wr_data` are 0.
- **Local misalignment check.** The check runs on the granted request, and the request is still granted and consumed. A request is rejected if any of these hold:
  - fetch with addr[1:0]≠0;
  - data with wr_mask=3 or rd_mask=0 and addr[1:0]≠0;
  - data with wr_mask=2 or rd_mask∈{1,3} and addr[0]=1.
- **Rejected requests.** A rejected request causes no memory access. Its response carries the error flag and data 0.
- **Granted requests.** The request fields pass straight to the memory ports.
- **Owner register.** Holds NONE, F or D, plus a local-error bit, and is loaded on every cycle.
- **Response routing.**
  - `*_rsp_valid` is high only for the registered owner.
  - The data response is `i_mem_rd_data`, forced to 0 for a store-only request (rd_mask=5).
  - The memory error flags are ORed into the owner's error outputs.
- **Non-owner outputs.** All response outputs of the port that does not own the response are 0.
- **Combined load and store.** A data request with both a write and a read is legal. The read returns the pre-write contents.

## Timing
- **Reset.** While `i_reset_n`=0:
  - the owner register is NONE and the streak counter is 0;
  - all `o_*_rsp_*` outputs are 0;
  - `o_f_gnt`=`o_d_gnt`=0;
  - the memory ports carry the idle drive.
- **Reset mid-operation.** An in-flight response is dropped and never reported.
- **Grant.** Combinational in the request cycle N.
- **Response.** Exactly cycle N+1. Latency is 1 and there is no backpressure: a requester must accept the response in the cycle it appears.
- **Throughput.** One access per cycle with no bubbles. Back-to-back grants to the same port give back-to-back responses.
- **Simultaneous grant and response.** A grant to port X and a response to port Y in the same cycle are independent of each other.

## Configuration
- **`MEM_ARB_STARVE_GUARD_EN` defined.**
  - A counter of width 4 increments on each cycle where data is granted while `i_f_req`=1.
  - It clears on any fetch grant and on any cycle with `i_f_req`=0.
  - When the counter equals `MAX_STREAK` and both ports request, fetch is granted and the counter clears.
- **Undefined.** Strict data priority. No counter is built.

## Test plan
- **Reset.** Assert `i_reset_n`=0 with both ports requesting.
  - Expect both gnt=0, both rsp_valid=0, and `o_mem_rd_mask`=5.
  - Release reset: the first grant goes to data.
- **Fetch word.** Preload 0x0=0x08000200, then request a fetch with addr=0x0 alone.
  - Expect `o_f_gnt` in cycle N.
  - Expect `o_f_rsp_valid`=1 and `o_f_rsp_data`=0x08000200 in N+1.
- **Store then load.** Store byte 0x80 to addr 0x6, then load BE from addr 0x6.
  - Expect the store ack with data 0.
  - Expect the load to return 0xFFFFFF80.
  - Expect BZ from the same address to return 0x00000080.
- **Misaligned.** Data word store to 0x2, then a fetch from 0x1.
  - Expect both granted, `o_mem_wr_mask` stays 0, and memory is unchanged.
  - Expect `o_d_rsp_err_misaligned`=1 and `o_f_rsp_err`=1 in the respective response cycles.
- **Starvation guard** (`MEM_ARB_STARVE_GUARD_EN`, `MAX_STREAK`=4). Hold both ports requesting continuously.
  - Expect the grant pattern D,D,D,D,F repeating.
  - With the macro undefined, expect D in every cycle.
- **Invalid mask.** Data request with rd_mask=6.
  - Expect `o_d_rsp_err_mask`=1 in N+1, and the fetch response outputs stay 0.
